// File: rtl/pipelined_carry_adder_pkg.sv
// Shared definitions for the pipelined carry adder: op encoding and segment sizing helpers.
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
      return (stages == 0) ? 0 : width / stages;
   endfunction

   function automatic bit stages_divide(input int unsigned width, input int unsigned stages);
      return (stages != 0) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for the pipelined carry adder.
interface pipelined_carry_adder_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

endinterface

// File: rtl/pipelined_carry_adder_carry_segment.sv
// One SEG-bit ripple slice: {co, s} = x + y + ci.
module carry_segment #(
   parameter int unsigned SEG = 8
) (
   input  logic [SEG-1:0] x,
   input  logic [SEG-1:0] y,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co
);

   logic [SEG:0] total;

   assign total   = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
   assign {co, s} = total;

endmodule

// File: rtl/pipelined_carry_adder.sv
// Adder/subtractor split into STAGES carry segments with a single global advance (stall) signal.
module pipelined_carry_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input logic                    clk,
   input logic                    rst,
   pipelined_carry_adder_if.slave bus
);

   localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
   localparam int unsigned MSB  = WIDTH - 1;
   localparam int unsigned LAST = STAGES - 1;

   if (!stages_divide(WIDTH, STAGES)) begin : g_div_check
      $error("pipelined_carry_adder: WIDTH must be an exact multiple of STAGES");
   end
   if ((WIDTH < 2) || (WIDTH > 128)) begin : g_width_check
      $error("pipelined_carry_adder: WIDTH must lie in 2..128");
   end

   logic                              adv;
   logic [WIDTH-1:0]                  b_eff;
   logic                              cin_eff;

   logic [STAGES-1:0]                 vld_q, vld_d;
   logic [STAGES-1:0]                 cy_q, cy_d;
   logic [STAGES-1:0][WIDTH-1:0]      sum_q, sum_d;
   logic [STAGES-1:0][WIDTH-1:0]      a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0]      b_q, b_d;

   logic [STAGES-1:0][SEG-1:0]        seg_x, seg_y, seg_s;
   logic [STAGES-1:0]                 seg_ci, seg_co;

   // Whole pipe moves or whole pipe holds; no per-stage bubble collapsing.
   assign adv     = ~vld_q[LAST] | bus.out_ready;
   assign b_eff   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
   assign cin_eff = (bus.op == OP_SUB) ? 1'b1 : bus.cin;

   always_comb begin
      seg_x     = '0;
      seg_y     = '0;
      seg_ci    = '0;
      seg_x[0]  = bus.a[SEG-1:0];
      seg_y[0]  = b_eff[SEG-1:0];
      seg_ci[0] = cin_eff;
      for (int k = 1; k < STAGES; k++) begin
         seg_x[k]  = a_q[k-1][k*SEG +: SEG];
         seg_y[k]  = b_q[k-1][k*SEG +: SEG];
         seg_ci[k] = cy_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      carry_segment #(
         .SEG(SEG)
      ) u_seg (
         .x (seg_x[k]),
         .y (seg_y[k]),
         .ci(seg_ci[k]),
         .s (seg_s[k]),
         .co(seg_co[k])
      );
   end

   always_comb begin
      vld_d    = '0;
      cy_d     = '0;
      sum_d    = '0;
      a_d      = '0;
      b_d      = '0;
      vld_d[0] = bus.in_valid;
      // Operand registers only capture on an accepted beat; bubbles leave them untouched.
      if (bus.in_valid) begin
         a_d[0]            = bus.a;
         b_d[0]            = b_eff;
         sum_d[0][SEG-1:0] = seg_s[0];
         cy_d[0]           = seg_co[0];
      end else begin
         a_d[0]   = a_q[0];
         b_d[0]   = b_q[0];
         sum_d[0] = sum_q[0];
         cy_d[0]  = cy_q[0];
      end
      for (int k = 1; k < STAGES; k++) begin
         vld_d[k]                = vld_q[k-1];
         a_d[k]                  = a_q[k-1];
         b_d[k]                  = b_q[k-1];
         sum_d[k]                = sum_q[k-1];
         sum_d[k][k*SEG +: SEG]  = seg_s[k];
         cy_d[k]                 = seg_co[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         cy_q  <= '0;
         sum_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else if (adv) begin
         vld_q <= vld_d;
         cy_q  <= cy_d;
         sum_q <= sum_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[LAST];
   assign bus.sum       = sum_q[LAST];
   assign bus.cout      = cy_q[LAST];
   assign bus.ovf       = (a_q[LAST][MSB] == b_q[LAST][MSB]) &
                          (sum_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed checks on an 8-bit/2-stage adder plus a scoreboarded random run on a 32-bit/4-stage one.
module tb_pipelined_carry_adder;
   import adder_pkg::*;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       op;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pipelined_carry_adder_if #(.WIDTH(8))  ifc8 ();
   pipelined_carry_adder_if #(.WIDTH(32)) ifc32 ();

   pipelined_carry_adder #(
      .WIDTH (8),
      .STAGES(2)
   ) u_dut8 (
      .clk(clk),
      .rst(rst),
      .bus(ifc8)
   );

   pipelined_carry_adder #(
      .WIDTH (32),
      .STAGES(4)
   ) u_dut32 (
      .clk(clk),
      .rst(rst),
      .bus(ifc32)
   );

   // a, b, cin, op, expected sum, cout, ovf
   vec_t single_vecs [8] = '{
      '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
      '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
      '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
      '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0},
      '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0},
      '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0},
      '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
      '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1}
   };

   vec_t b2b_vecs [8] = '{
      '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0},
      '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0},
      '{8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0},
      '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
      '{8'h09, 8'h03, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0},
      '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0},
      '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
      '{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0}
   };

   task automatic put8(input bit v, input vec_t t);
      ifc8.in_valid = v;
      ifc8.a        = t.a;
      ifc8.b        = t.b;
      ifc8.cin      = t.cin;
      ifc8.op       = t.op;
   endtask

   task automatic test_reset();
      rst              = 1'b1;
      put8(1'b0, '0);
      ifc8.out_ready   = 1'b1;
      ifc32.in_valid   = 1'b0;
      ifc32.a          = '0;
      ifc32.b          = '0;
      ifc32.cin        = 1'b0;
      ifc32.op         = 1'b0;
      ifc32.out_ready  = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if (ifc8.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b, expected 0", ifc8.out_valid);
      end
      n_tests++;
      if ({ifc8.sum, ifc8.cout, ifc8.ovf} !== 10'h000) begin
         n_fail++;
         $display("FAIL reset_data: got sum=%h cout=%b ovf=%b, expected 00/0/0",
                  ifc8.sum, ifc8.cout, ifc8.ovf);
      end
      n_tests++;
      if (ifc32.out_valid !== 1'b0 || ifc32.sum !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_wide: got valid=%b sum=%h, expected 0/0",
                  ifc32.out_valid, ifc32.sum);
      end
      rst = 1'b0;
      @(negedge clk);
      ifc8.out_ready = 1'b0;
      #1;
      n_tests++;
      if (ifc8.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b, expected 1", ifc8.in_ready);
      end
      ifc8.out_ready = 1'b1;
   endtask

   task automatic test_single_latency();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         put8(1'b1, single_vecs[i]);
         #1;
         n_tests++;
         if (ifc8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single%0d_in_ready: got %b, expected 1", i, ifc8.in_ready);
         end
         @(negedge clk);
         put8(1'b0, '0);
         #1;
         n_tests++;
         if (ifc8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single%0d_early: got out_valid=%b, expected 0", i, ifc8.out_valid);
         end
         @(negedge clk);
         #1;
         n_tests++;
         if (ifc8.out_valid !== 1'b1 || {ifc8.sum, ifc8.cout, ifc8.ovf} !==
             {single_vecs[i].s, single_vecs[i].co, single_vecs[i].ov}) begin
            n_fail++;
            $display("FAIL single%0d_result: got v=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                     i, ifc8.out_valid, ifc8.sum, ifc8.cout, ifc8.ovf,
                     single_vecs[i].s, single_vecs[i].co, single_vecs[i].ov);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_bubble();
      vec_t x = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
      vec_t y = '{8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0};
      logic [3:0] exp_v = 4'b0101;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0)      put8(1'b1, x);
         else if (c == 2) put8(1'b1, y);
         else             put8(1'b0, '0);
         #1;
         if (c >= 2) begin
            n_tests++;
            if (ifc8.out_valid !== exp_v[c-2]) begin
               n_fail++;
               $display("FAIL bubble_valid_c%0d: got %b, expected %b", c, ifc8.out_valid, exp_v[c-2]);
            end
         end
         if (c == 2 || c == 4) begin
            n_tests++;
            if (ifc8.sum !== ((c == 2) ? x.s : y.s) || ifc8.cout !== ((c == 2) ? x.co : y.co)) begin
               n_fail++;
               $display("FAIL bubble_data_c%0d: got sum=%h cout=%b", c, ifc8.sum, ifc8.cout);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int seen = 0;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         if (c < 8) put8(1'b1, b2b_vecs[c]);
         else       put8(1'b0, '0);
         #1;
         if (c < 8) begin
            n_tests++;
            if (ifc8.in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_in_ready_c%0d: got %b, expected 1", c, ifc8.in_ready);
            end
         end
         if (c >= 2 && c < 10) begin
            n_tests++;
            if (ifc8.out_valid !== 1'b1 || {ifc8.sum, ifc8.cout, ifc8.ovf} !==
                {b2b_vecs[c-2].s, b2b_vecs[c-2].co, b2b_vecs[c-2].ov}) begin
               n_fail++;
               $display("FAIL b2b_beat%0d: got v=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                        c - 2, ifc8.out_valid, ifc8.sum, ifc8.cout, ifc8.ovf,
                        b2b_vecs[c-2].s, b2b_vecs[c-2].co, b2b_vecs[c-2].ov);
            end
         end
         if (ifc8.out_valid === 1'b1) seen++;
      end
      n_tests++;
      if (seen != 8) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d valid cycles, expected 8", seen);
      end
   endtask

   task automatic test_backpressure();
      vec_t bp [3] = '{
         '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0},
         '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
         '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0}
      };
      // Cycle-by-cycle: which beat should be on the output (-1 = none).
      int exp_out [9] = '{-1, -1, 0, 0, 0, 0, 1, 2, -1};
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         ifc8.out_ready = !(c >= 2 && c <= 4);
         if (c <= 1)      put8(1'b1, bp[c]);
         else if (c <= 5) put8(1'b1, bp[2]);
         else             put8(1'b0, '0);
         #1;
         if (c >= 2 && c <= 4) begin
            n_tests++;
            if (ifc8.in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_in_ready_c%0d: got %b, expected 0", c, ifc8.in_ready);
            end
         end
         if (exp_out[c] < 0) begin
            if (c >= 2) begin
               n_tests++;
               if (ifc8.out_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL bp_extra_c%0d: got out_valid=%b, expected 0", c, ifc8.out_valid);
               end
            end
         end else begin
            n_tests++;
            if (ifc8.out_valid !== 1'b1 || {ifc8.sum, ifc8.cout, ifc8.ovf} !==
                {bp[exp_out[c]].s, bp[exp_out[c]].co, bp[exp_out[c]].ov}) begin
               n_fail++;
               $display("FAIL bp_out_c%0d: got v=%b sum=%h cout=%b ovf=%b, expected beat %0d",
                        c, ifc8.out_valid, ifc8.sum, ifc8.cout, ifc8.ovf, exp_out[c]);
            end
         end
      end
      ifc8.out_ready = 1'b1;
   endtask

   task automatic test_reset_flush();
      vec_t r0 = '{8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
      vec_t r1 = '{8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
      @(negedge clk);
      put8(1'b1, r0);
      @(negedge clk);
      put8(1'b1, r1);
      @(negedge clk);
      put8(1'b0, '0);
      ifc8.out_ready = 1'b0;
      rst            = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if (ifc8.out_valid !== 1'b0 || {ifc8.sum, ifc8.cout, ifc8.ovf} !== 10'h000) begin
         n_fail++;
         $display("FAIL flush_state: got v=%b sum=%h cout=%b ovf=%b, expected 0 00 0 0",
                  ifc8.out_valid, ifc8.sum, ifc8.cout, ifc8.ovf);
      end
      n_tests++;
      if (ifc8.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_in_ready: got %b, expected 1", ifc8.in_ready);
      end
      ifc8.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if (ifc8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_leak_c%0d: got out_valid=%b sum=%h, expected 0",
                     c, ifc8.out_valid, ifc8.sum);
         end
      end
   endtask

   task automatic test_random_wide();
      localparam int N = 10000;
      logic [33:0] expq [$];
      logic [33:0] exp_r, held, got_r;
      logic [31:0] ra, rb, rs;
      logic        rc, rov;
      bit          hold_pend = 1'b0;
      int          sent = 0;
      int          cycles = 0;
      while ((sent < N || expq.size() != 0) && cycles < 60000) begin
         @(negedge clk);
         cycles++;
         ifc32.out_ready = ($urandom_range(3) != 0);
         ifc32.in_valid  = (sent < N) && ($urandom_range(3) != 0);
         ifc32.a         = $urandom;
         ifc32.b         = $urandom;
         ifc32.cin       = 1'($urandom_range(1));
         ifc32.op        = 1'($urandom_range(1));
         #1;
         got_r = {ifc32.ovf, ifc32.cout, ifc32.sum};
         if (hold_pend) begin
            n_tests++;
            if (ifc32.out_valid !== 1'b1 || got_r !== held) begin
               n_fail++;
               $display("FAIL rand_hold: got v=%b %h, expected 1 %h", ifc32.out_valid, got_r, held);
            end
         end
         hold_pend = (ifc32.out_valid === 1'b1) && !ifc32.out_ready;
         held      = got_r;
         if (ifc32.out_valid === 1'b1 && ifc32.out_ready) begin
            n_tests++;
            if (expq.size() == 0) begin
               n_fail++;
               $display("FAIL rand_spurious: got %h, expected no beat", got_r);
            end else begin
               exp_r = expq.pop_front();
               if (got_r !== exp_r) begin
                  n_fail++;
                  $display("FAIL rand_beat: got ovf/cout/sum=%h, expected %h", got_r, exp_r);
               end
            end
         end
         if (ifc32.in_valid && ifc32.in_ready === 1'b1) begin
            ra = ifc32.a;
            rb = ifc32.b;
            if (ifc32.op == OP_SUB) begin
               rs  = ra - rb;
               rc  = (ra >= rb);
               rov = (ra[31] != rb[31]) && (rs[31] != ra[31]);
            end else begin
               {rc, rs} = {1'b0, ra} + {1'b0, rb} + {32'h0, ifc32.cin};
               rov      = (ra[31] == rb[31]) && (rs[31] != ra[31]);
            end
            expq.push_back({rov, rc, rs});
            sent++;
         end
      end
      ifc32.in_valid = 1'b0;
      n_tests++;
      if (sent != N || expq.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain: got sent=%0d pending=%0d, expected %0d/0",
                  sent, expq.size(), N);
      end
   endtask

   initial begin
      test_reset();
      test_single_latency();
      test_bubble();
      test_back_to_back();
      test_backpressure();
      test_reset_flush();
      test_random_wide();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
